i2f_operand_stage: RTL and testbench
====================================

I2F_OPERAND_STAGE -- requirements
Module: i2f_operand_stage

Interface
REQ-001 Parameter TAG_W, default 7, width of the opaque tag carried with each op.
REQ-002 Parameter CNT_W, default 32, width of the accepted-op counter.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 io_req_valid  input  1  request present.
REQ-006 io_req_ready  output  1  stage can accept request this cycle.
REQ-007 io_req_typ  input  2  0=W (signed 32), 1=WU (unsigned 32), 2=L (signed 64), 3=LU (unsigned 64).
REQ-008 io_req_data  input  64  raw integer register operand.
REQ-009 io_req_rm  input  3  instruction rounding mode; 7 = dynamic.
REQ-010 io_req_tag  input  TAG_W  op identifier.
REQ-011 io_frm  input  3  CSR rounding mode, used when io_req_rm==7.
REQ-012 io_kill  input  1  flush all buffered ops.
REQ-013 io_resp_valid  output  1  head entry valid.
REQ-014 io_resp_ready  input  1  downstream int-to-recoded-float converter consumes head.
REQ-015 io_resp_signedIn  output  1  drives converter signedIn.
REQ-016 io_resp_in  output  64  drives converter 64-bit integer input.
REQ-017 io_resp_roundingMode  output  3  drives converter roundingMode.
REQ-018 io_resp_tag  output  TAG_W  tag of head entry.
REQ-019 io_resp_illegalRm  output  1  head entry has reserved rounding mode.
REQ-020 io_opCount  output  CNT_W  accepted-op count (present only per REQ-036).

Function
REQ-021 Stage SHALL be a 2-entry FIFO; io_req_ready = (occupancy < 2), independent of io_resp_ready.
REQ-022 Push on io_req_valid && io_req_ready; pop on io_resp_valid && io_resp_ready; push and pop in same cycle at occupancy 1 SHALL leave occupancy 1 with correct ordering.
REQ-023 Latency: op accepted at edge N SHALL appear on io_resp_* with io_resp_valid=1 from cycle N+1 when FIFO was empty; all resp outputs come from registers.
REQ-024 Operand: W -> sign-extend data[31:0], signedIn=1; WU -> zero-extend data[31:0], signedIn=0; L -> data, signedIn=1; LU -> data, signedIn=0.
REQ-025 Effective rm = io_frm if io_req_rm==7 else io_req_rm, sampled at acceptance; later io_frm changes SHALL NOT affect buffered entries.
REQ-026 Effective rm in {5,6,7} SHALL set illegalRm=1 and store roundingMode=0; otherwise illegalRm=0.
REQ-027 When io_resp_valid=0, io_resp_signedIn, io_resp_in, io_resp_roundingMode, io_resp_tag, io_resp_illegalRm SHALL all be 0.
REQ-028 io_kill=1 SHALL set occupancy to 0 at next edge, overriding any same-cycle push or pop; io_req_ready stays per REQ-021 during kill.
REQ-029 Entry storage SHALL be a 2-slot ring with 1-bit read/write pointers wrapping 1->0.

Reset
REQ-030 reset_n low SHALL asynchronously clear occupancy, pointers, entry payloads and counter to 0.
REQ-031 During and after reset until first push: io_resp_valid=0, io_req_ready=1, all payload outputs 0.
REQ-032 Reset asserted mid-operation SHALL discard buffered ops; no partial resp emitted after release.

Configuration
REQ-033 Macro I2F_OPERAND_STAGE_PERF_EN SHALL compile in io_opCount and its counter.
REQ-034 With macro: counter increments by 1 per accepted push (not cancelled by same-cycle kill), wraps 2^CNT_W-1 -> 0.
REQ-035 Without macro: port io_opCount and counter SHALL be absent; all other behaviour identical.
REQ-036 io_opCount SHALL exist only when I2F_OPERAND_STAGE_PERF_EN is defined.

Structure
REQ-037 Shared package i2f_pkg SHALL hold typ enum (W/WU/L/LU), rm constants (RNE=0..RMM=4, DYN=7) and entry struct {signedIn, in, roundingMode, tag, illegalRm}.
REQ-038 One sub-module i2f_operand_fmt (combinational typ/rm decode producing an entry struct); FIFO in top module.

Verification
REQ-039 typ=W, data=0x0000_0000_FFFF_FFFE, rm=0 -> resp_in=0xFFFF_FFFF_FFFF_FFFE, signedIn=1, roundingMode=0, one cycle later.
REQ-040 typ=WU, same data, rm=7, frm=3 -> resp_in=0x0000_0000_FFFF_FFFE, signedIn=0, roundingMode=3; frm changed to 1 after acceptance -> still 3.
REQ-041 typ=L, rm=5 -> illegalRm=1, roundingMode=0; rm=7 with frm=6 -> illegalRm=1.
REQ-042 resp_ready=0, push tags 1,2 -> req_ready=0 on third attempt; release -> tags 1 then 2 in order, occupancy 1 push+pop keeps order.
REQ-043 Two entries buffered, kill with simultaneous req_valid -> next cycle resp_valid=0, payload 0; with PERF_EN, io_opCount counts the killed-cycle push.
REQ-044 reset_n pulsed low asynchronously with 2 entries held -> resp_valid=0 immediately, req_ready=1, io_opCount=0.

Source files
------------

// File: rtl/i2f_pkg.sv
// Shared types for the int-to-float operand stage: op type enum,
// rounding-mode constants and the buffered entry struct.
package i2f_pkg;

  typedef enum logic [1:0] {
    TYP_W  = 2'd0,
    TYP_WU = 2'd1,
    TYP_L  = 2'd2,
    TYP_LU = 2'd3
  } typ_e;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [2:0] RM_DYN = 3'd7;

  // Widest tag any instance may carry; instances use the low TAG_W bits.
  localparam int TAG_MAX = 32;

  typedef struct packed {
    logic               signedIn;
    logic [63:0]        in;
    logic [2:0]         roundingMode;
    logic [TAG_MAX-1:0] tag;
    logic               illegalRm;
  } entry_t;

endpackage

// File: rtl/i2f_operand_fmt.sv
// Combinational decode of op type and rounding mode into a
// converter-ready entry.
module i2f_operand_fmt
  import i2f_pkg::*;
(
  input  logic [1:0]         typ,
  input  logic [63:0]        data,
  input  logic [2:0]         rm,
  input  logic [2:0]         frm,
  input  logic [TAG_MAX-1:0] tag,
  output entry_t             entry
);

  logic [2:0] effRm;
  logic       illegal;

  always_comb begin
    effRm   = (rm == RM_DYN) ? frm : rm;
    illegal = (effRm > RM_RMM);
    entry              = '0;
    entry.tag          = tag;
    entry.illegalRm    = illegal;
    entry.roundingMode = illegal ? RM_RNE : effRm;
    unique case (1'b1)
      typ == TYP_W: begin
        entry.in       = {{32{data[31]}}, data[31:0]};
        entry.signedIn = 1'b1;
      end
      typ == TYP_WU: begin
        entry.in       = {32'd0, data[31:0]};
        entry.signedIn = 1'b0;
      end
      typ == TYP_L: begin
        entry.in       = data;
        entry.signedIn = 1'b1;
      end
      default: begin
        entry.in       = data;
        entry.signedIn = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/i2f_operand_stage.sv
// Two-entry operand buffer in front of the int-to-recoded-float converter.
// Define I2F_OPERAND_STAGE_PERF_EN to add the io_opCount accepted-op counter.
module i2f_operand_stage
  import i2f_pkg::*;
#(
  parameter int TAG_W = 7,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [1:0]       io_req_typ,
  input  logic [63:0]      io_req_data,
  input  logic [2:0]       io_req_rm,
  input  logic [TAG_W-1:0] io_req_tag,
  input  logic [2:0]       io_frm,
  input  logic             io_kill,
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic             io_resp_signedIn,
  output logic [63:0]      io_resp_in,
  output logic [2:0]       io_resp_roundingMode,
  output logic [TAG_W-1:0] io_resp_tag,
  output logic             io_resp_illegalRm
`ifdef I2F_OPERAND_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] io_opCount
`endif
);

  entry_t     fmtEntry;
  entry_t     mem [2];
  entry_t     head;
  logic [1:0] count;
  logic       wrPtr;
  logic       rdPtr;
  logic       push;
  logic       pop;
  logic       unusedTagHi;

  i2f_operand_fmt uFmt (
    .typ  (io_req_typ),
    .data (io_req_data),
    .rm   (io_req_rm),
    .frm  (io_frm),
    .tag  (TAG_MAX'(io_req_tag)),
    .entry(fmtEntry)
  );

  assign io_req_ready  = (count < 2'd2);
  assign io_resp_valid = (count != 2'd0);
  assign push = io_req_valid && io_req_ready;
  assign pop  = io_resp_valid && io_resp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (io_kill) begin
      count <= 2'd0;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
    end else begin
      if (push) begin
        mem[wrPtr] <= fmtEntry;
        wrPtr      <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload is forced to zero whenever nothing is presented.
  assign head = io_resp_valid ? mem[rdPtr] : '0;

  assign io_resp_signedIn     = head.signedIn;
  assign io_resp_in           = head.in;
  assign io_resp_roundingMode = head.roundingMode;
  assign io_resp_tag          = head.tag[TAG_W-1:0];
  assign io_resp_illegalRm    = head.illegalRm;
  assign unusedTagHi          = ^head.tag;

`ifdef I2F_OPERAND_STAGE_PERF_EN
  // Counts every accepted push, including one dropped by a same-cycle kill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_opCount <= '0;
    end else if (push) begin
      io_opCount <= io_opCount + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_i2f_operand_stage.sv
// Randomized and directed bench for i2f_operand_stage against a
// queue-based reference model.
module tb_i2f_operand_stage;

  localparam int TAG_W = 7;
  localparam int CNT_W = 32;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             io_req_valid = 1'b0;
  logic             io_req_ready;
  logic [1:0]       io_req_typ = '0;
  logic [63:0]      io_req_data = '0;
  logic [2:0]       io_req_rm = '0;
  logic [TAG_W-1:0] io_req_tag = '0;
  logic [2:0]       io_frm = '0;
  logic             io_kill = 1'b0;
  logic             io_resp_valid;
  logic             io_resp_ready = 1'b0;
  logic             io_resp_signedIn;
  logic [63:0]      io_resp_in;
  logic [2:0]       io_resp_roundingMode;
  logic [TAG_W-1:0] io_resp_tag;
  logic             io_resp_illegalRm;
`ifdef I2F_OPERAND_STAGE_PERF_EN
  logic [CNT_W-1:0] io_opCount;
`endif

  i2f_operand_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .io_req_valid        (io_req_valid),
    .io_req_ready        (io_req_ready),
    .io_req_typ          (io_req_typ),
    .io_req_data         (io_req_data),
    .io_req_rm           (io_req_rm),
    .io_req_tag          (io_req_tag),
    .io_frm              (io_frm),
    .io_kill             (io_kill),
    .io_resp_valid       (io_resp_valid),
    .io_resp_ready       (io_resp_ready),
    .io_resp_signedIn    (io_resp_signedIn),
    .io_resp_in          (io_resp_in),
    .io_resp_roundingMode(io_resp_roundingMode),
    .io_resp_tag         (io_resp_tag),
    .io_resp_illegalRm   (io_resp_illegalRm)
`ifdef I2F_OPERAND_STAGE_PERF_EN
    ,
    .io_opCount          (io_opCount)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit             s;
    bit [63:0]      in;
    bit [2:0]       rm;
    bit [TAG_W-1:0] tag;
    bit             ill;
  } exp_t;

  exp_t           q[$];
  bit [CNT_W-1:0] opCnt;
  int             checks;
  int             failures;

  wire [77:0] dutVec = {io_resp_valid, io_req_ready, io_resp_signedIn,
                        io_resp_in, io_resp_roundingMode, io_resp_tag,
                        io_resp_illegalRm};

  function automatic exp_t model(bit [1:0] typ, bit [63:0] d, bit [2:0] rm,
                                 bit [2:0] frm, bit [TAG_W-1:0] tag);
    exp_t e;
    int   eff;
    eff   = (rm == 7) ? int'(frm) : int'(rm);
    e.ill = (eff >= 5);
    e.rm  = e.ill ? 3'd0 : 3'(eff);
    e.tag = tag;
    case (typ)
      2'd0: begin e.in = 64'(longint'(int'(d[31:0]))); e.s = 1; end
      2'd1: begin e.in = 64'(d[31:0]); e.s = 0; end
      2'd2: begin e.in = d; e.s = 1; end
      default: begin e.in = d; e.s = 0; end
    endcase
    return e;
  endfunction

  function automatic bit [77:0] expVec();
    bit [77:0] v;
    v = '0;
    v[76] = (q.size() < 2);
    if (q.size() > 0)
      v = {1'b1, q.size() < 2, q[0].s, q[0].in, q[0].rm, q[0].tag, q[0].ill};
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge pass, advance the model.
  task automatic step(bit v, bit [1:0] typ, bit [63:0] d, bit [2:0] rm,
                      bit [TAG_W-1:0] tag, bit [2:0] frm, bit kill, bit rr);
    bit   acc;
    bit   pp;
    exp_t e;
    io_req_valid  = v;
    io_req_typ    = typ;
    io_req_data   = d;
    io_req_rm     = rm;
    io_req_tag    = tag;
    io_frm        = frm;
    io_kill       = kill;
    io_resp_ready = rr;
    acc = v && (q.size() < 2);
    pp  = rr && (q.size() > 0);
    e   = model(typ, d, rm, frm, tag);
    @(posedge clock);
    #1;
    if (acc) opCnt++;
    if (kill) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    io_req_valid = 1'b0;
    io_kill      = 1'b0;
  endtask

  task automatic idle(bit rr);
    step(0, 0, 0, 0, 0, io_frm, 0, rr);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    q.delete();
    opCnt = '0;
    #12;
    checks++;
    if (dutVec !== 78'(1) << 76) begin
      failures++;
      $display("FAIL reset_during got=%h exp=%h", dutVec, 78'(1) << 76);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (dutVec !== expVec()) begin
      failures++;
      $display("FAIL reset_after got=%h exp=%h", dutVec, expVec());
    end
`ifdef I2F_OPERAND_STAGE_PERF_EN
    checks++;
    if (io_opCount !== '0) begin
      failures++;
      $display("FAIL reset_opcount got=%0d exp=0", io_opCount);
    end
`endif
  endtask

  task automatic test_fmt();
    step(1, 0, 64'h0000_0000_FFFF_FFFE, 0, 5, 0, 0, 0);
    checks++;
    if (io_resp_valid !== 1'b1 || io_resp_in !== 64'hFFFF_FFFF_FFFF_FFFE ||
        io_resp_signedIn !== 1'b1 || io_resp_roundingMode !== 3'd0) begin
      failures++;
      $display("FAIL fmt_w got=%b %h %b %0d exp=1 fffffffffffffffe 1 0",
               io_resp_valid, io_resp_in, io_resp_signedIn, io_resp_roundingMode);
    end
    idle(1);
    step(1, 1, 64'h0000_0000_FFFF_FFFE, 7, 6, 3, 0, 0);
    io_frm = 3'd1;
    idle(0);
    checks++;
    if (io_resp_in !== 64'h0000_0000_FFFF_FFFE || io_resp_signedIn !== 1'b0 ||
        io_resp_roundingMode !== 3'd3) begin
      failures++;
      $display("FAIL fmt_wu_dyn got=%h %b %0d exp=00000000fffffffe 0 3",
               io_resp_in, io_resp_signedIn, io_resp_roundingMode);
    end
    idle(1);
    step(1, 2, 64'h8000_0000_1234_5678, 5, 7, 0, 0, 0);
    checks++;
    if (io_resp_illegalRm !== 1'b1 || io_resp_roundingMode !== 3'd0 ||
        io_resp_in !== 64'h8000_0000_1234_5678) begin
      failures++;
      $display("FAIL fmt_l_rm5 got=%b %0d %h exp=1 0 8000000012345678",
               io_resp_illegalRm, io_resp_roundingMode, io_resp_in);
    end
    idle(1);
    step(1, 2, 64'h1, 7, 8, 6, 0, 0);
    checks++;
    if (io_resp_illegalRm !== 1'b1 || dutVec !== expVec()) begin
      failures++;
      $display("FAIL fmt_dyn_frm6 got=%h exp=%h", dutVec, expVec());
    end
    idle(1);
  endtask

  task automatic test_order();
    step(1, 3, 64'hA, 1, 1, 0, 0, 0);
    step(1, 3, 64'hB, 2, 2, 0, 0, 0);
    io_req_valid = 1'b1;
    #1;
    checks++;
    if (io_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL order_full_ready got=%b exp=0", io_req_ready);
    end
    step(1, 3, 64'hC, 3, 3, 0, 0, 0);
    checks++;
    if (io_resp_tag !== 7'd1 || dutVec !== expVec()) begin
      failures++;
      $display("FAIL order_head1 got=%h exp=%h", dutVec, expVec());
    end
    idle(1);
    checks++;
    if (io_resp_tag !== 7'd2 || dutVec !== expVec()) begin
      failures++;
      $display("FAIL order_head2 got=%h exp=%h", dutVec, expVec());
    end
    step(1, 0, 64'hD, 4, 4, 0, 0, 1);
    checks++;
    if (io_resp_tag !== 7'd4 || dutVec !== expVec()) begin
      failures++;
      $display("FAIL order_pushpop got=%h exp=%h", dutVec, expVec());
    end
    idle(1);
    checks++;
    if (dutVec !== expVec()) begin
      failures++;
      $display("FAIL order_drained got=%h exp=%h", dutVec, expVec());
    end
  endtask

  task automatic test_kill();
    step(1, 2, 64'h11, 0, 9, 0, 0, 0);
    step(1, 2, 64'h22, 0, 10, 0, 0, 0);
    step(1, 2, 64'h33, 0, 11, 0, 1, 1);
    checks++;
    if (dutVec !== (78'(1) << 76)) begin
      failures++;
      $display("FAIL kill_full got=%h exp=%h", dutVec, 78'(1) << 76);
    end
    step(1, 0, 64'h44, 1, 12, 0, 0, 0);
    step(1, 0, 64'h55, 1, 13, 0, 1, 0);
    checks++;
    if (dutVec !== expVec()) begin
      failures++;
      $display("FAIL kill_push got=%h exp=%h", dutVec, expVec());
    end
`ifdef I2F_OPERAND_STAGE_PERF_EN
    checks++;
    if (io_opCount !== opCnt) begin
      failures++;
      $display("FAIL kill_opcount got=%0d exp=%0d", io_opCount, opCnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom), {$urandom, $urandom},
           3'($urandom), TAG_W'($urandom), 3'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      checks++;
      if (dutVec !== expVec()) begin
        failures++;
        $display("FAIL random[%0d] got=%h exp=%h", i, dutVec, expVec());
      end
`ifdef I2F_OPERAND_STAGE_PERF_EN
      checks++;
      if (io_opCount !== opCnt) begin
        failures++;
        $display("FAIL random_opcount[%0d] got=%0d exp=%0d", i, io_opCount, opCnt);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    idle(1);
    step(1, 1, 64'h66, 2, 20, 0, 0, 0);
    step(1, 1, 64'h77, 2, 21, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    q.delete();
    opCnt = '0;
    #1;
    checks++;
    if (dutVec !== (78'(1) << 76)) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", dutVec, 78'(1) << 76);
    end
`ifdef I2F_OPERAND_STAGE_PERF_EN
    checks++;
    if (io_opCount !== '0) begin
      failures++;
      $display("FAIL async_reset_opcount got=%0d exp=0", io_opCount);
    end
`endif
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);
    checks++;
    if (dutVec !== expVec()) begin
      failures++;
      $display("FAIL post_reset got=%h exp=%h", dutVec, expVec());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fmt();
    test_order();
    test_kill();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
